// File: rtl/match_controller.sv
// Pong match sequencer: scores points, paces serves by frame ticks, declares a winner.
// Optional MATCH_SCORE_HEX_EN adds registered active-low seven-segment score outputs.
module match_controller #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       vs_in,
    input  logic       p1_win,
    input  logic       p2_win,
    output logic       round_rst,
    output logic       done,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
`ifdef MATCH_SCORE_HEX_EN
    output logic [6:0] hex_p1,
    output logic [6:0] hex_p2,
`endif
    output logic [1:0] winner
);

    typedef enum logic [2:0] {IDLE, RESTART, SERVE, PLAY, SCORED, OVER} state_t;

    localparam logic [3:0] WIN     = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);

    state_t     state;
    logic [7:0] frame_cnt;
    logic       start_q, vs_q, p1_q, p2_q;

    logic       start_rise, p1_rise, p2_rise, frame_tick;
    logic [7:0] cnt_next;

    always_comb begin
        start_rise = start & ~start_q;
        p1_rise    = p1_win & ~p1_q;
        p2_rise    = p2_win & ~p2_q;
        frame_tick = vs_q & ~vs_in;
        cnt_next   = frame_cnt + 8'd1;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state     <= IDLE;
            p1_score  <= '0;
            p2_score  <= '0;
            winner    <= '0;
            done      <= 1'b1;
            round_rst <= 1'b0;
            frame_cnt <= '0;
            // Preload with live inputs so no edge is seen on the first cycle.
            start_q   <= start;
            vs_q      <= vs_in;
            p1_q      <= p1_win;
            p2_q      <= p2_win;
        end else begin
            start_q   <= start;
            vs_q      <= vs_in;
            p1_q      <= p1_win;
            p2_q      <= p2_win;
            done      <= 1'b1;
            round_rst <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        p1_score  <= '0;
                        p2_score  <= '0;
                        winner    <= '0;
                        round_rst <= 1'b1;
                        state     <= RESTART;
                    end
                end
                RESTART: begin
                    frame_cnt <= '0;
                    state     <= SERVE;
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (cnt_next == SERVE_N) begin
                            done  <= 1'b0;
                            state <= PLAY;
                        end else begin
                            frame_cnt <= cnt_next;
                        end
                    end
                end
                PLAY: begin
                    // Simultaneous rises are a draw: no score, round still replays.
                    if (p1_rise || p2_rise) begin
                        state <= SCORED;
                        if (p1_rise && !p2_rise) p1_score <= p1_score + 4'd1;
                        if (p2_rise && !p1_rise) p2_score <= p2_score + 4'd1;
                    end else begin
                        done <= 1'b0;
                    end
                end
                SCORED: begin
                    if (p1_score == WIN) begin
                        winner <= 2'b01;
                        state  <= OVER;
                    end else if (p2_score == WIN) begin
                        winner <= 2'b10;
                        state  <= OVER;
                    end else begin
                        round_rst <= 1'b1;
                        state     <= RESTART;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MATCH_SCORE_HEX_EN
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hex_p1 <= 7'h40;
            hex_p2 <= 7'h40;
        end else begin
            hex_p1 <= seg7(p1_score);
            hex_p2 <= seg7(p2_score);
        end
    end
`endif

endmodule

// File: tb/tb_match_controller.sv
// Directed scoreboard bench for match_controller (WIN_SCORE=2, SERVE_FRAMES=3).
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst, start, vs_in, p1_win, p2_win;
    logic       round_rst, done;
    logic [3:0] p1_score, p2_score;
    logic [1:0] winner;
`ifdef MATCH_SCORE_HEX_EN
    logic [6:0] hex_p1, hex_p2;
`endif

    match_controller #(.WIN_SCORE(2), .SERVE_FRAMES(3)) dut (
        .vga_clk  (clk),
        .rst      (rst),
        .start    (start),
        .vs_in    (vs_in),
        .p1_win   (p1_win),
        .p2_win   (p2_win),
        .round_rst(round_rst),
        .done     (done),
        .p1_score (p1_score),
        .p2_score (p2_score),
`ifdef MATCH_SCORE_HEX_EN
        .hex_p1   (hex_p1),
        .hex_p2   (hex_p2),
`endif
        .winner   (winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] val;
        int          at;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    logic        armed = 1'b0;
    logic [11:0] prev = 12'hFFF;
    logic [11:0] snap;

    // Reference model of the outputs, advanced by the stimulus.
    logic       m_rr, m_done;
    logic [3:0] m_p1, m_p2;
    logic [1:0] m_win;

    // Every change of the output vector must match the next queued expectation.
    always @(negedge clk) begin
        if (armed) begin
            snap = {round_rst, done, p1_score, p2_score, winner};
            if (snap !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: got rr=%0b done=%0b p1=%0d p2=%0d win=%b at cyc %0d, required no change",
                             round_rst, done, p1_score, p2_score, winner, cyc);
                end else begin
                    e = q.pop_front();
                    if (snap !== e.val || (e.at != 0 && cyc != e.at)) begin
                        failures++;
                        $display("FAIL %s: got rr=%0b done=%0b p1=%0d p2=%0d win=%b at cyc %0d, required rr=%0b done=%0b p1=%0d p2=%0d win=%b at cyc %0d",
                                 e.name, round_rst, done, p1_score, p2_score, winner, cyc,
                                 e.val[11], e.val[10], e.val[9:6], e.val[5:2], e.val[1:0], e.at);
                    end
                end
                prev = snap;
            end
        end
    end

    task automatic push(input string nm, input int at);
        q.push_back('{val: {m_rr, m_done, m_p1, m_p2, m_win}, at: at, name: nm});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        m_rr = 1'b1; m_done = 1'b1; m_p1 = '0; m_p2 = '0; m_win = '0;
        push("restart_pulse", cyc + 1);
        tick();
        start = 1'b0;
        m_rr = 1'b0;
        push("restart_end", cyc + 1);
    endtask

    task automatic serve();
        for (int f = 0; f < 3; f++) begin
            tick();
            vs_in = 1'b0;
            if (f == 2) begin
                m_done = 1'b0;
                push("play_start", cyc + 1);
            end
            tick();
            vs_in = 1'b1;
            idle(2);
        end
    endtask

    task automatic point(input logic a, input logic b, input int hold, input string nm);
        int c;
        tick();
        p1_win = a;
        p2_win = b;
        c = cyc;
        if (a && !b) m_p1 = m_p1 + 4'd1;
        if (b && !a) m_p2 = m_p2 + 4'd1;
        m_done = 1'b1;
        push(nm, c + 1);
        if (m_p1 == 4'd2 || m_p2 == 4'd2) begin
            m_win = (m_p1 == 4'd2) ? 2'b01 : 2'b10;
            push("winner", c + 2);
        end else begin
            m_rr = 1'b1;
            push("score_restart", c + 2);
            m_rr = 1'b0;
            push("score_restart_end", c + 3);
        end
        idle(hold);
        p1_win = 1'b0;
        p2_win = 1'b0;
    endtask

    task automatic reset_dut(input string nm);
        tick();
        rst = 1'b1;
        m_rr = 1'b0; m_done = 1'b1; m_p1 = '0; m_p2 = '0; m_win = '0;
        push(nm, cyc + 1);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vs_in = 1'b1; p1_win = 1'b0; p2_win = 1'b0;
        m_rr = 1'b0; m_done = 1'b1; m_p1 = '0; m_p2 = '0; m_win = '0;
        push("reset_state", 0);
        armed = 1'b1;
        idle(3);
        rst = 1'b0;

        // Idle: no output activity, point flags ignored outside PLAY.
        idle(40);
        p1_win = 1'b1;
        idle(5);
        p1_win = 1'b0;
        idle(55);

        do_start();
        serve();
        point(1'b1, 1'b0, 50, "p1_held_point");
        serve();
        point(1'b1, 1'b1, 5, "draw");
        reset_dut("reset_in_serve");
        idle(5);

        do_start();
        serve();
        point(1'b0, 1'b1, 5, "p2_point1");
        serve();
        point(1'b0, 1'b1, 5, "p2_point2");
        idle(3);
        p2_win = 1'b1;
        idle(5);
        p2_win = 1'b0;
        idle(3);

        do_start();
        serve();
        point(1'b1, 1'b0, 5, "p1_point1");
        serve();
        point(1'b1, 1'b0, 5, "p1_point2");
        idle(3);
        reset_dut("reset_in_over");
        idle(3);
`ifdef MATCH_SCORE_HEX_EN
        checks++;
        if (hex_p1 !== 7'h40 || hex_p2 !== 7'h40) begin
            failures++;
            $display("FAIL hex_after_reset: got %h/%h, required 40/40", hex_p1, hex_p2);
        end
`endif
        idle(10);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: %0d expected output changes never appeared, next is %s",
                     q.size(), q[0].name);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
